// File: rtl/rmii_tx_pkg.sv
// rmii_tx_pkg: shared definitions for the RMII transmit framer.
//   tx_state_t     - framer sequencer states
//   PREAMBLE_BYTE  - 0x55 preamble byte, SFD_BYTE - 0xD5 start-of-frame delimiter
//   FCS_DIBITS     - number of dibit cycles used to send the 32-bit FCS
//   CRC_RESIDUE    - receiver-side CRC register value over payload+FCS of a good frame
//   crc32_bit()    - one bit step of the reflected Ethernet CRC32
package rmii_tx_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_SFD,
      ST_DATA,
      ST_PAD,
      ST_FCS,
      ST_IFG
   } tx_state_t;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam int          FCS_DIBITS    = 16;
   localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;
   localparam logic [31:0] CRC_POLY      = 32'hEDB88320;

   // Reflected CRC32: data enters LSB-first, the register shifts right.
   function automatic logic [31:0] crc32_bit(input logic [31:0] crc, input logic b);
      logic [31:0] sh;
      sh = {1'b0, crc[31:1]};
      return (crc[0] ^ b) ? (sh ^ CRC_POLY) : sh;
   endfunction

endpackage

// File: rtl/crc_gen.sv
// crc_gen: 2-bit-per-cycle Ethernet CRC32 engine.
// Ports:
//   clk_i      - clock
//   rst_i      - asynchronous active-high reset (state -> all-ones)
//   clr_i      - synchronous clear (state -> all-ones), has priority over en_i
//   en_i       - fold dibit_i into the CRC state this cycle
//   dibit_i    - dibit, bit 0 is earlier on the wire
//   crc_next_o - state after folding dibit_i (uncomplemented), combinational
module crc_gen
   import rmii_tx_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        clr_i,
   input  logic        en_i,
   input  logic [1:0]  dibit_i,
   output logic [31:0] crc_next_o
);

   logic [31:0] crc_q;

   always_comb begin
      crc_next_o = crc32_bit(crc32_bit(crc_q, dibit_i[0]), dibit_i[1]);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         crc_q <= '1;
      end else if (clr_i) begin
         crc_q <= '1;
      end else if (en_i) begin
         crc_q <= crc_next_o;
      end
   end

endmodule

// File: rtl/rmii_tx_framer.sv
// rmii_tx_framer: RMII (2-bit) transmit frame sequencer.
// Emits preamble + SFD, serialises payload bytes LSB-first as dibits, appends
// the CRC32 FCS and enforces the inter-frame gap.
// Build option: define RMII_TX_PAD_EN to zero-pad short payloads up to
// MIN_FRAME_BYTES before the FCS; without it short frames go out unpadded.
// Ports:
//   clk_i      - 50 MHz RMII reference clock
//   rst_i      - asynchronous active-high reset
//   data_i     - payload byte (dest MAC through end of payload)
//   valid_i    - data_i valid
//   last_i     - data_i is the final payload byte
//   ready_o    - byte consumed this cycle when valid_i & ready_o
//   txd_o      - RMII TXD[1:0], registered
//   tx_en_o    - RMII TX_EN, registered
//   busy_o     - high whenever the sequencer is not idle
//   underrun_o - one-cycle pulse when a frame is aborted for lack of data
module rmii_tx_framer
   import rmii_tx_pkg::*;
#(
   parameter int PREAMBLE_BYTES  = 7,
   parameter int IFG_DIBITS      = 48,
   parameter int MIN_FRAME_BYTES = 60
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic [7:0] data_i,
   input  logic       valid_i,
   input  logic       last_i,
   output logic       ready_o,
   output logic [1:0] txd_o,
   output logic       tx_en_o,
   output logic       busy_o,
   output logic       underrun_o
);

   localparam int CYC_W = 16;
   localparam int CNT_W = $clog2(MIN_FRAME_BYTES + 1);

   tx_state_t        state_q, state_n;
   logic [1:0]       idx_q, idx_n;
   logic [CYC_W-1:0] cyc_q, cyc_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic             last_seen_q, last_seen_n;
   logic [7:0]       byte_q;
   logic [31:0]      fcs_q;
   logic             clr_q;

   logic [1:0]       dibit_c;
   logic             en_c, crc_en_c, abort_c, fcs_load_c, take_c;
   logic [31:0]      crc_next;

   // A byte is requested only in the last dibit of SFD or of a non-final
   // payload byte, so the byte register refills exactly when it empties.
   assign ready_o = ((state_q == ST_SFD) || ((state_q == ST_DATA) && !last_seen_q))
                    && (idx_q == 2'd3);
   assign take_c  = ready_o && valid_i;
   assign busy_o  = (state_q != ST_IDLE);

   crc_gen u_crc (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .clr_i      (clr_q),
      .en_i       (crc_en_c),
      .dibit_i    (dibit_c),
      .crc_next_o (crc_next)
   );

   always_comb begin
      state_n     = state_q;
      idx_n       = idx_q;
      cyc_n       = cyc_q;
      cnt_n       = cnt_q;
      last_seen_n = last_seen_q;
      dibit_c     = 2'b00;
      en_c        = 1'b0;
      crc_en_c    = 1'b0;
      abort_c     = 1'b0;
      fcs_load_c  = 1'b0;

      if (take_c) begin
         last_seen_n = last_i;
         if (cnt_q != CNT_W'(MIN_FRAME_BYTES)) begin
            cnt_n = cnt_q + CNT_W'(1);
         end
      end

      case (state_q)
         ST_IDLE: begin
            last_seen_n = 1'b0;
            cnt_n       = '0;
            idx_n       = 2'd0;
            // The first preamble dibit is launched from IDLE so tx_en_o
            // rises one cycle after valid_i and the gap stays exact.
            if (valid_i) begin
               dibit_c = PREAMBLE_BYTE[1:0];
               en_c    = 1'b1;
               cyc_n   = CYC_W'(1);
               state_n = ST_PREAMBLE;
            end
         end
         ST_PREAMBLE: begin
            dibit_c = PREAMBLE_BYTE[1:0];
            en_c    = 1'b1;
            cyc_n   = cyc_q + CYC_W'(1);
            if (cyc_q == CYC_W'(PREAMBLE_BYTES * 4 - 1)) begin
               idx_n   = 2'd0;
               state_n = ST_SFD;
            end
         end
         ST_SFD: begin
            dibit_c = SFD_BYTE[{idx_q, 1'b0} +: 2];
            en_c    = 1'b1;
            idx_n   = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
               if (valid_i) begin
                  state_n = ST_DATA;
               end else begin
                  abort_c = 1'b1;
                  cyc_n   = '0;
                  state_n = ST_IFG;
               end
            end
         end
         ST_DATA: begin
            dibit_c  = byte_q[{idx_q, 1'b0} +: 2];
            en_c     = 1'b1;
            crc_en_c = 1'b1;
            idx_n    = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
               cyc_n = '0;
               if (last_seen_q) begin
`ifdef RMII_TX_PAD_EN
                  if (cnt_q < CNT_W'(MIN_FRAME_BYTES)) begin
                     state_n = ST_PAD;
                  end else begin
                     fcs_load_c = 1'b1;
                     state_n    = ST_FCS;
                  end
`else
                  fcs_load_c = 1'b1;
                  state_n    = ST_FCS;
`endif
               end else if (!valid_i) begin
                  abort_c = 1'b1;
                  state_n = ST_IFG;
               end
            end
         end
`ifdef RMII_TX_PAD_EN
         ST_PAD: begin
            dibit_c  = 2'b00;
            en_c     = 1'b1;
            crc_en_c = 1'b1;
            idx_n    = idx_q + 2'd1;
            if (idx_q == 2'd3) begin
               cnt_n = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(MIN_FRAME_BYTES - 1)) begin
                  fcs_load_c = 1'b1;
                  cyc_n      = '0;
                  state_n    = ST_FCS;
               end
            end
         end
`endif
         ST_FCS: begin
            dibit_c = fcs_q[1:0];
            en_c    = 1'b1;
            cyc_n   = cyc_q + CYC_W'(1);
            if (cyc_q == CYC_W'(FCS_DIBITS - 1)) begin
               cyc_n   = '0;
               state_n = ST_IFG;
            end
         end
         ST_IFG: begin
            cyc_n = cyc_q + CYC_W'(1);
            if (cyc_q == CYC_W'(IFG_DIBITS - 1)) begin
               state_n = ST_IDLE;
            end
         end
         default: begin
            state_n = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= ST_IDLE;
         idx_q       <= 2'd0;
         cyc_q       <= '0;
         cnt_q       <= '0;
         last_seen_q <= 1'b0;
         clr_q       <= 1'b1;
         txd_o       <= 2'b00;
         tx_en_o     <= 1'b0;
         underrun_o  <= 1'b0;
      end else begin
         state_q     <= state_n;
         idx_q       <= idx_n;
         cyc_q       <= cyc_n;
         cnt_q       <= cnt_n;
         last_seen_q <= last_seen_n;
         clr_q       <= (state_q == ST_IFG) || (state_q == ST_IDLE);
         txd_o       <= dibit_c;
         tx_en_o     <= en_c;
         underrun_o  <= abort_c;
      end
   end

   // The FCS register is loaded with the complement of the CRC that already
   // includes the dibit leaving in this same cycle, then drained LSB-first.
   always_ff @(posedge clk_i) begin
      if (take_c) begin
         byte_q <= data_i;
      end
      if (fcs_load_c) begin
         fcs_q <= ~crc_next;
      end else if (state_q == ST_FCS) begin
         fcs_q <= {2'b00, fcs_q[31:2]};
      end
   end

endmodule
